// File: rtl/wb_commit_if.sv
// Writeback bus between the MEM stage, the commit unit and the register-file
// write port. The master side is the environment (MEM stage and register
// file); the slave side is the commit unit.
interface wb_commit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [1:0]      memtoreg;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] mem_out;
    logic [XLEN-1:0] return_addr;
    logic [XLEN-1:0] imm_out;
    logic [XLEN-1:0] pc_signed_offset;
    logic            flush;
    logic            rf_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    modport master (
        output in_valid, opcode, memtoreg, funct3, addr_lo, rd_addr,
        output alu_out, mem_out, return_addr, imm_out, pc_signed_offset,
        output flush, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, opcode, memtoreg, funct3, addr_lo, rd_addr,
        input  alu_out, mem_out, return_addr, imm_out, pc_signed_offset,
        input  flush, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_commit_unit.sv
// Buffered writeback stage: selects the result of each instruction, queues
// it in a small commit FIFO, drains the FIFO into the register-file write
// port under backpressure, forwards queued values to two read ports and
// counts retired instructions.
module wb_commit_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_commit_if.slave             bus,
    input  logic [4:0]             fwd_raddr0,
    input  logic [4:0]             fwd_raddr1,
    output logic                   fwd_hit0,
    output logic                   fwd_hit1,
    output logic [XLEN-1:0]        fwd_data0,
    output logic [XLEN-1:0]        fwd_data1,
    output logic [CNT_W-1:0]       retire_count,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // ---------------- result select ----------------
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result_data;
    logic            result_we;

    // Align and extend the load word, then pick the result source.
    always_comb begin
        byte_sel  = bus.mem_out[{bus.addr_lo, 3'b000} +: 8];
        half_sel  = bus.addr_lo[1] ? bus.mem_out[31:16] : bus.mem_out[15:0];
        case (bus.funct3)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = bus.mem_out;
        endcase

        result_data = '0;
        case (bus.memtoreg)
            2'b00:   result_data = bus.alu_out;
            2'b01:   result_data = load_data;
            2'b10: begin
                if (bus.opcode == OP_JAL || bus.opcode == OP_JALR)
                    result_data = bus.return_addr;
                else if (bus.opcode == OP_LUI)
                    result_data = bus.imm_out;
                else if (bus.opcode == OP_AUIPC)
                    result_data = bus.pc_signed_offset;
                else
                    result_data = '0;
            end
            default: result_data = '0;
        endcase

        // x0 and no-write instructions still occupy a slot so they retire in order.
        result_we = (bus.memtoreg != 2'b11) && (bus.rd_addr != 5'd0);
    end

    // ---------------- commit FIFO ----------------
    logic            ent_we   [DEPTH];
    logic [4:0]      ent_addr [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [OW-1:0]    occ_reg, occ_next;
    logic [CNT_W-1:0] retire_reg, retire_next;

    logic            empty;
    logic            full;
    logic            head_we;
    logic            push_fire;
    logic            pop_fire;

    assign empty   = (occ_reg == '0);
    assign full    = (occ_reg == OW'(DEPTH));
    assign head_we = ent_we[rd_ptr_reg];

    // in_ready only looks at registered occupancy, so rf_ready never reaches it.
    assign push_fire = bus.in_valid && !full && !bus.flush;
    assign pop_fire  = !empty && (bus.rf_ready || !head_we) && !bus.flush;

    // Next-state for pointers, occupancy and the retire counter.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        occ_next    = occ_reg;
        retire_next = retire_reg;
        if (bus.flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            occ_next    = '0;
        end else begin
            if (push_fire)
                wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop_fire) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
                retire_next = retire_reg + CNT_W'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   occ_next = occ_reg + OW'(1);
                2'b01:   occ_next = occ_reg - OW'(1);
                default: occ_next = occ_reg;
            endcase
        end
    end

    // Control state with immediate reset; queued entries are simply abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            retire_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
            retire_reg <= retire_next;
        end
    end

    // Entry storage; contents are only meaningful while counted by occupancy.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            ent_we[wr_ptr_reg]   <= result_we;
            ent_addr[wr_ptr_reg] <= bus.rd_addr;
            ent_data[wr_ptr_reg] <= result_data;
        end
    end

    // ---------------- head / register-file port ----------------
    assign bus.in_ready = !full;
    assign bus.rf_we    = !empty && head_we;
    assign bus.rf_waddr = bus.rf_we ? ent_addr[rd_ptr_reg] : 5'd0;
    assign bus.rf_wdata = bus.rf_we ? ent_data[rd_ptr_reg] : '0;

    assign retire_count = retire_reg;
    assign occupancy    = occ_reg;

    // ---------------- forwarding ----------------
    logic [4:0] fwd_raddr [2];
    assign fwd_raddr[0] = fwd_raddr0;
    assign fwd_raddr[1] = fwd_raddr1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic            hit;
            logic [XLEN-1:0] data;

            // Walk from oldest to youngest so the youngest match overrides.
            always_comb begin
                hit  = 1'b0;
                data = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    if ((OW'(k) < occ_reg) &&
                        ent_we[rd_ptr_reg + AW'(k)] &&
                        (ent_addr[rd_ptr_reg + AW'(k)] == fwd_raddr[gi]) &&
                        (fwd_raddr[gi] != 5'd0)) begin
                        hit  = 1'b1;
                        data = ent_data[rd_ptr_reg + AW'(k)];
                    end
                end
            end
        end
    endgenerate

    assign fwd_hit0  = g_fwd[0].hit;
    assign fwd_data0 = g_fwd[0].data;
    assign fwd_hit1  = g_fwd[1].hit;
    assign fwd_data1 = g_fwd[1].data;
endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Parametrised, buffered writeback stage for the RV32 core. Selects the result per instruction: ALU, aligned/extended load data, link address, LUI immediate or AUIPC sum. Queues the result in a DEPTH-entry commit FIFO and drains it into the register-file write port under `rf_ready` backpressure. Also provides two-port operand forwarding out of the queue and an instruction-retire counter. It replaces the combinational writeback mux between the MEM stage and the register file.

## Interface
- XLEN, 32: datapath width (32 only for load alignment; other logic width-generic)
- DEPTH, 2: commit FIFO entries; power of two, ≥2
- CNT_W, 64: retire counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  unit can accept; equals !full
- opcode  in  7  instruction opcode
- memtoreg  in  2  00 ALU, 01 load, 10 upper/jump, 11 no write
- funct3  in  3  load size/sign
- addr_lo  in  2  load byte address bits [1:0]
- rd_addr  in  5  destination register
- alu_out, mem_out, return_addr, imm_out, pc_signed_offset  in  XLEN each  candidate results
- flush  in  1  discard all queued entries
- rf_ready  in  1  register file accepts write this cycle
- rf_we  out  1  write request
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- fwd_raddr0, fwd_raddr1  in  5  forwarding query addresses
- fwd_hit0, fwd_hit1  out  1  query matched a queued write
- fwd_data0, fwd_data1  out  XLEN  forwarded value
- retire_count  out  CNT_W  retired instructions
- occupancy  out  $clog2(DEPTH)+1  queued entries

## Operation
- Result select (combinational, pre-queue):
  - memtoreg 00: alu_out.
  - memtoreg 01: load data.
  - memtoreg 10: by opcode. 1101111/1100111 → return_addr; 0110111 → imm_out; 0010111 → pc_signed_offset; any other opcode → 0.
- Load alignment, selected by funct3:
  - 000 LB: byte at addr_lo, sign-extended.
  - 001 LH: half at addr_lo[1], sign-extended.
  - 100 LBU / 101 LHU: same selection as LB / LH, zero-extended.
  - 010 and any other value: full word. addr_lo[0] is ignored for halves.
- Entry write-enable flag we = (memtoreg != 11) && (rd_addr != 0). Entries with we=0 are still queued and still retire.
- Push: in_valid && in_ready stores {we, rd_addr, data} at the tail.
- Head outputs:
  - rf_we = !empty && head.we; rf_waddr/rf_wdata = head fields.
  - Outputs are 0 when empty or when head.we=0.
- Pop: when !empty && (rf_ready || !head.we). A we=0 entry drains without waiting for rf_ready.
- retire_count: +1 on each pop; wraps modulo 2^CNT_W.
- Forwarding, per port:
  - Search all valid entries with we=1 and waddr == fwd_raddr.
  - Youngest match wins; fwd_hit=1 and fwd_data = its data.
  - No match, or raddr = 0: fwd_hit=0, fwd_data=0.
  - An entry popping this cycle is still visible to the search.
  - Same-cycle input is not visible.
- flush: synchronous.
  - Empties the FIFO: pointers and occupancy go to 0.
  - No pop and no retire that cycle, even if rf_ready=1.
  - A push in the same cycle is dropped.

## Timing
- Reset (async, immediate): pointers, occupancy, retire_count = 0. Hence rf_we=0, rf_waddr=0, rf_wdata=0, fwd_hit*=0, fwd_data*=0, in_ready=1.
- Latency: an instruction accepted at edge N, with an empty FIFO, appears at head (rf_we) in cycle N+1. Its write commits at the first edge where rf_ready=1.
- in_ready depends only on registered occupancy. There is no combinational path from rf_ready to in_ready.
- Full: in_ready=0 even if a pop occurs that cycle.
- Simultaneous push and pop (not full): occupancy unchanged, both pointers advance, pointers wrap modulo DEPTH.
- Ordering: writes reach the register file strictly in acceptance order.
- in_valid with in_ready=0: nothing captured. MEM stage holds its inputs.
- Reset asserted mid-stream: queued entries are lost and not retired.

## Test plan
- Select/align: push memtoreg=01, funct3=000, addr_lo=2, mem_out=0x12_80_34_56 → rf_wdata=0xFFFFFF80. Push funct3=101, addr_lo=2 → 0x00001280. Push memtoreg=10, opcode=0010111, pc_signed_offset=0x1000 → 0x00001000.
- x0 and no-write: push rd_addr=0 and memtoreg=11 with rf_ready=0 → rf_we stays 0, both entries drain, retire_count=2.
- Backpressure: rf_ready=0, push 3 writes (DEPTH=2) → third is held (in_ready=0), occupancy=2. Raise rf_ready → writes x5,x6,x7 commit in order on 3 consecutive edges.
- Forwarding: queue x5=0x11 then x5=0x22 with rf_ready=0, fwd_raddr0=5 → hit0=1, data0=0x22. fwd_raddr1=0 → hit1=0.
- Flush: occupancy=2, assert flush together with in_valid and rf_ready → occupancy=0, no rf write, retire_count unchanged.
- Async reset: assert rst between clock edges with FIFO full → outputs zero immediately, in_ready=1, retire_count=0.
